// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter: shares one memory port between fetch (IF) and the memory
// stage (MM). MM has priority with a bounded streak; transfers time out.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int TIMEOUT       = 15,
  parameter int MAX_MM_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_busy,
  input  logic          mm_req,
  input  logic          mm_we,
  input  logic [AW-1:0] mm_addr,
  input  logic [DW-1:0] mm_wdata,
  output logic [DW-1:0] mm_rdata,
  output logic          mm_ack,
  output logic          mm_busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  output logic          bus_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_MM_STREAK + 1);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TCNT_MAX   = TW'(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MM_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_XFER = 2'd1,
    MM_XFER = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          mm_ack_q, mm_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mm_rdata_q, mm_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic if_elig, mm_elig, grant_if, grant_mm, done, timed_out;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    mm_rdata_d  = mm_rdata_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    if_ack_d    = 1'b0;
    mm_ack_d    = 1'b0;
    bus_err_d   = 1'b0;
    grant_if    = 1'b0;
    grant_mm    = 1'b0;
    done        = 1'b0;
    timed_out   = 1'b0;

    // A requester is not eligible in its own ack cycle, so it is never re-granted on a stale req.
    if_elig = if_req & ~if_ack_q;
    mm_elig = mm_req & ~mm_ack_q;

    case (state_q)
      IDLE: begin
        if (if_elig && mm_elig && (streak_q == STREAK_MAX)) begin
          grant_if = 1'b1;
        end else if (mm_elig) begin
          grant_mm = 1'b1;
        end else if (if_elig) begin
          grant_if = 1'b1;
        end
      end
      IF_XFER, MM_XFER: begin
        if (mem_rdy && mem_req_q) begin
          done = 1'b1;
        end else if (tcnt_q == TCNT_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else if (tcnt_q != TCNT_MAX) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_if) begin
      state_d    = IF_XFER;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = if_addr;
      tcnt_d     = '0;
      streak_d   = '0;
    end
    if (grant_mm) begin
      state_d     = MM_XFER;
      mem_req_d   = 1'b1;
      mem_we_d    = mm_we;
      mem_addr_d  = mm_addr;
      mem_wdata_d = mm_wdata;
      tcnt_d      = '0;
      if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + SW'(1);
      end
    end

    if (done) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      bus_err_d = timed_out;
      if (state_q == IF_XFER) begin
        if_ack_d   = 1'b1;
        if_rdata_d = timed_out ? '0 : mem_rdata;
      end else begin
        mm_ack_d = 1'b1;
        // Write completions leave the previous load data in place.
        if (timed_out) begin
          mm_rdata_d = '0;
        end else if (!mem_we_q) begin
          mm_rdata_d = mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      mm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      mm_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
      streak_q    <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      mm_ack_q    <= mm_ack_d;
      if_rdata_q  <= if_rdata_d;
      mm_rdata_q  <= mm_rdata_d;
      bus_err_q   <= bus_err_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign mm_ack    = mm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mm_rdata  = mm_rdata_q;
  assign bus_err   = bus_err_q;
  assign if_busy   = if_req & ~if_ack_q;
  assign mm_busy   = mm_req & ~mm_ack_q;

endmodule
`default_nettype wire
